// File: rtl/count_control.sv
// count_control: synchronizes and debounces the board buttons/switches and emits the
// enable/count_direction step controls for the up/down counter. Held-button auto-repeat
// is built only when COUNT_CONTROL_AUTO_REPEAT_EN is defined.
module count_control #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_CYCLES     = 100_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_CYCLES   = 20_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  input  logic run,
  input  logic dir_sw,
  output logic enable,
  output logic count_direction,
  output logic running
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam int TK_W = $clog2(TICK_CYCLES);
  localparam int UP = 0;
  localparam int DN = 1;
  localparam int RN = 2;
  localparam int DR = 3;

  if (DEBOUNCE_CYCLES < 2 || TICK_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("count_control: illegal parameter value");
  end

  typedef enum logic [1:0] {IDLE, RUN, HOLD_UP, HOLD_DOWN} state_t;

  state_t          state_q, state_d;
  logic [3:0]      raw, sync1_q, sync2_q, lvl_q, lvl_d;
  logic [DB_W-1:0] db_cnt_q [4];
  logic [DB_W-1:0] db_cnt_d [4];
  logic [1:0]      btn_prev_q, press_q, press_d;
  logic [TK_W-1:0] tick_q, tick_d;
  logic            enable_q, enable_d, dir_q, dir_d, running_q, running_d;
  logic            up_p, dn_p, both_p, any_held, tick_wrap, press_next, rep_fire;

  assign raw = {dir_sw, run, btn_down, btn_up};

  // Debounce: a differing synchronized level must persist DEBOUNCE_CYCLES cycles to be accepted
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lvl_d[i]    = lvl_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != lvl_q[i]) begin
        if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) lvl_d[i] = ~lvl_q[i];
        else db_cnt_d[i] = db_cnt_q[i] + 1'b1;
      end
    end
  end

  assign press_d    = lvl_q[DN:UP] & ~btn_prev_q;
  assign up_p       = press_q[UP] & ~press_q[DN];
  assign dn_p       = press_q[DN] & ~press_q[UP];
  assign both_p     = press_q[UP] & press_q[DN];
  assign any_held   = lvl_q[UP] | lvl_q[DN];
  assign tick_wrap  = (state_q == RUN) && (tick_q == TK_W'(TICK_CYCLES - 1));
  assign press_next = press_d[UP] ^ press_d[DN];
  assign tick_d     = (state_q == RUN && !tick_wrap) ? tick_q + 1'b1 : '0;

`ifdef COUNT_CONTROL_AUTO_REPEAT_EN
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_CYCLES) ? REPEAT_DELAY : REPEAT_CYCLES;
  localparam int HD_W     = $clog2(HOLD_MAX + 1);

  logic [HD_W-1:0] hold_q, hold_d;
  logic            rep_q, rep_d, holding;

  // First repeat waits REPEAT_DELAY from the press pulse, later ones REPEAT_CYCLES apart
  always_comb begin
    holding  = (state_q == HOLD_UP && lvl_q[UP]) || (state_q == HOLD_DOWN && lvl_q[DN]);
    rep_fire = holding &&
               (hold_q == (rep_q ? HD_W'(REPEAT_CYCLES - 1) : HD_W'(REPEAT_DELAY - 1)));
    hold_d   = '0;
    rep_d    = 1'b0;
    if (holding) begin
      hold_d = rep_fire ? '0 : hold_q + 1'b1;
      rep_d  = rep_q | rep_fire;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (up_p)                        state_d = HOLD_UP;
        else if (dn_p)                   state_d = HOLD_DOWN;
        else if (lvl_q[RN] && !any_held) state_d = RUN;
      end
      RUN: begin
        if (up_p)                         state_d = HOLD_UP;
        else if (dn_p)                    state_d = HOLD_DOWN;
        else if (!lvl_q[RN] && !any_held) state_d = IDLE;
      end
      HOLD_UP:   if (!lvl_q[UP]) state_d = lvl_q[RN] ? RUN : IDLE;
      HOLD_DOWN: if (!lvl_q[DN]) state_d = lvl_q[RN] ? RUN : IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // A tick is also dropped when a press pulse follows next cycle, keeping pulses non-adjacent
  always_comb begin
    enable_d = 1'b0;
    dir_d    = dir_q;
    if ((state_q == IDLE || state_q == RUN) && up_p) begin
      enable_d = 1'b1;
      dir_d    = 1'b1;
    end else if ((state_q == IDLE || state_q == RUN) && dn_p) begin
      enable_d = 1'b1;
      dir_d    = 1'b0;
    end else if (tick_wrap && !both_p && !press_next) begin
      enable_d = 1'b1;
      dir_d    = lvl_q[DR];
    end else if (rep_fire) begin
      enable_d = 1'b1;
      dir_d    = (state_q == HOLD_UP);
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      lvl_q      <= '0;
      btn_prev_q <= '0;
      press_q    <= '0;
      tick_q     <= '0;
      enable_q   <= 1'b0;
      dir_q      <= 1'b1;
      running_q  <= 1'b0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      lvl_q      <= lvl_d;
      btn_prev_q <= lvl_q[DN:UP];
      press_q    <= press_d;
      tick_q     <= tick_d;
      enable_q   <= enable_d;
      dir_q      <= dir_d;
      running_q  <= running_d;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
    end
  end

  assign enable          = enable_q;
  assign count_direction = dir_q;
  assign running         = running_q;

endmodule

// File: tb/tb_count_control.sv
// Scoreboard bench for count_control: stimulus pushes expected pulses/running edges,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_count_control;

  localparam int DB = 4;
  localparam int TK = 10;
  localparam int RD = 20;
  localparam int RC = 5;
  localparam int PRESS_LAT = DB + 4;  // input change at negedge c -> pulse seen after edge c+PRESS_LAT
  localparam int LVL_LAT   = DB + 3;  // input change at negedge c -> state change after edge c+LVL_LAT

  typedef struct {
    int   cyc;
    logic val;
  } ev_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, run = 1'b0, dir_sw = 1'b0;
  logic enable, count_direction, running;

  ev_t  pulse_q[$];
  ev_t  run_q[$];
  ev_t  m_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic mon_on = 1'b0;
  logic run_prev = 1'b0;

  count_control #(
    .DEBOUNCE_CYCLES(DB),
    .TICK_CYCLES    (TK),
    .REPEAT_DELAY   (RD),
    .REPEAT_CYCLES  (RC)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .btn_up         (btn_up),
    .btn_down       (btn_down),
    .run            (run),
    .dir_sw         (dir_sw),
    .enable         (enable),
    .count_direction(count_direction),
    .running        (running)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic push_pulse(input int c, input logic d);
    ev_t e;
    e.cyc = c;
    e.val = d;
    pulse_q.push_back(e);
  endtask

  task automatic push_run(input int c, input logic v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    run_q.push_back(e);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %b, expected %b (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (mon_on) begin
      while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
        m_e    = pulse_q.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL pulse_missing: no enable, expected pulse at cyc %0d dir %b", m_e.cyc, m_e.val);
      end
      if (enable === 1'b1) begin
        checks = checks + 1;
        if (pulse_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL pulse_unexpected: pulse at cyc %0d dir %b, expected none", cyc, count_direction);
        end else begin
          m_e = pulse_q.pop_front();
          if (m_e.cyc != cyc || m_e.val !== count_direction) begin
            errors = errors + 1;
            $display("FAIL pulse: got cyc %0d dir %b, expected cyc %0d dir %b",
                     cyc, count_direction, m_e.cyc, m_e.val);
          end
        end
      end else if (enable !== 1'b0) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL enable_x: got %b at cyc %0d, expected 0/1", enable, cyc);
      end
      while (run_q.size() > 0 && run_q[0].cyc < cyc) begin
        m_e    = run_q.pop_front();
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL running_missing: no edge, expected running=%b at cyc %0d", m_e.val, m_e.cyc);
      end
      if (running !== run_prev) begin
        checks = checks + 1;
        if (run_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL running_unexpected: running=%b at cyc %0d, expected no change", running, cyc);
        end else begin
          m_e = run_q.pop_front();
          if (m_e.cyc != cyc || m_e.val !== running) begin
            errors = errors + 1;
            $display("FAIL running: got %b at cyc %0d, expected %b at cyc %0d",
                     running, cyc, m_e.val, m_e.cyc);
          end
        end
        run_prev = running;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c2, cd, w, cr, c4, c5, p;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      {btn_up, btn_down, run, dir_sw} = 4'($urandom);
      @(negedge clock);
      check_bit("rst_enable", enable, 1'b0);
      check_bit("rst_dir", count_direction, 1'b1);
      check_bit("rst_running", running, 1'b0);
    end
    {btn_up, btn_down, run, dir_sw} = 4'b0000;
    reset  = 1'b1;
    mon_on = 1'b1;
    repeat (10) @(negedge clock);

    // Bounce rejection then one steady press
    for (int i = 0; i < 5; i++) begin
      btn_up = 1'b1;
      repeat (2) @(negedge clock);
      btn_up = 1'b0;
      repeat (2) @(negedge clock);
    end
    btn_up = 1'b1;
    push_pulse(cyc + PRESS_LAT, 1'b1);
    repeat (15) @(negedge clock);
    btn_up = 1'b0;
    repeat (15) @(negedge clock);

    // Run mode, direction switch changes mid-run
    c2     = cyc;
    run    = 1'b1;
    dir_sw = 1'b0;
    push_run(c2 + LVL_LAT, 1'b1);
    for (int k = 1; k <= 5; k++) push_pulse(c2 + LVL_LAT + TK * k, (k >= 4));
    wait_until(c2 + 32);
    dir_sw = 1'b1;

    // Down press landing on the sixth tick wrap
    w  = c2 + LVL_LAT + TK * 6;
    cd = w - PRESS_LAT;
    wait_until(cd);
    btn_down = 1'b1;
    push_pulse(w, 1'b0);
    push_run(w, 1'b0);
    cr = cd + 20;
    wait_until(cr);
    btn_down = 1'b0;
    push_run(cr + LVL_LAT, 1'b1);
    push_pulse(cr + LVL_LAT + TK, 1'b1);
    wait_until(cr + LVL_LAT + TK + 1);
    run = 1'b0;
    push_run(cyc + LVL_LAT, 1'b0);
    repeat (20) @(negedge clock);

    // Simultaneous presses give nothing
    btn_up   = 1'b1;
    btn_down = 1'b1;
    repeat (15) @(negedge clock);
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (15) @(negedge clock);

    // Reset while down is held: fresh press after release
    c4       = cyc;
    btn_down = 1'b1;
    push_pulse(c4 + PRESS_LAT, 1'b0);
    wait_until(c4 + 15);
    reset = 1'b0;
    @(negedge clock);
    check_bit("midrst_enable", enable, 1'b0);
    check_bit("midrst_dir", count_direction, 1'b1);
    check_bit("midrst_running", running, 1'b0);
    reset = 1'b1;
    push_pulse(cyc + PRESS_LAT, 1'b0);
    repeat (10) @(negedge clock);
    btn_down = 1'b0;
    repeat (15) @(negedge clock);

    // Long hold of up
    c5     = cyc;
    btn_up = 1'b1;
    p      = c5 + PRESS_LAT;
    push_pulse(p, 1'b1);
`ifdef COUNT_CONTROL_AUTO_REPEAT_EN
    for (int k = 0; k < 4; k++) push_pulse(p + RD + RC * k, 1'b1);
`endif
    repeat (40) @(negedge clock);
    btn_up = 1'b0;
    repeat (20) @(negedge clock);

    checks = checks + 1;
    if (pulse_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL pulse_pending: %0d expected pulses not seen, expected 0", pulse_q.size());
    end
    checks = checks + 1;
    if (run_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL running_pending: %0d expected edges not seen, expected 0", run_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
